// File: rtl/final_project_pio_pkg.sv
// Shared constants for the start PIO: register addresses, CTRL bit positions
// and the req/ack handshake state encoding.
package final_project_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_OUTSET = 2'd2;
  localparam logic [1:0] ADDR_OUTCLR = 2'd3;

  localparam int unsigned CTRL_GO   = 0;
  localparam int unsigned CTRL_BUSY = 0;
  localparam int unsigned CTRL_DONE = 1;
  localparam int unsigned CTRL_ERR  = 2;
  localparam int unsigned CTRL_TMO  = 3;
  localparam int unsigned CTRL_IE   = 4;

  typedef logic [1:0] hs_state_t;

  localparam hs_state_t StIdle    = 2'd0;
  localparam hs_state_t StReq     = 2'd1;
  localparam hs_state_t StRelease = 2'd2;

endpackage

// File: rtl/final_project_req_ack_fsm.sv
// Four-phase req/ack handshake with a per-phase timeout counter.
// TIMEOUT_CYCLES = 0 disables the timeout.
module final_project_req_ack_fsm
  import final_project_pio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic hw_ack,
  output logic hw_req,
  output logic busy,
  output logic done_pulse,
  output logic timeout_pulse
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TmoEn = (TIMEOUT_CYCLES != 0);

  hs_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hw_req_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_pulse    = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        // An ack arriving on the last allowed cycle still counts as success.
        if (hw_ack) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else if (TmoEn && (cnt_q == CntLast)) begin
          state_d       = StIdle;
          timeout_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (!hw_ack) begin
          state_d    = StIdle;
          done_pulse = 1'b1;
        end else if (TmoEn && (cnt_q == CntLast)) begin
          state_d       = StIdle;
          timeout_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hw_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hw_req_q <= (state_d == StReq);
    end
  end

  assign hw_req = hw_req_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: rtl/final_project_hardware_start_pio.sv
// Avalon-MM command PIO: DATA/CTRL/OUTSET/OUTCLR registers driving a req/ack handshake.
// Define FINAL_PROJECT_START_PIO_IRQ_EN to add the IE bit and the irq output.
module final_project_hardware_start_pio
  import final_project_pio_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE    = '0,
  parameter int unsigned            TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  hw_req,
  input  logic                  hw_ack
`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [31:0]           rd_d;
  logic                  wr, ctrl_wr, err_set, start;
  logic                  busy, done_pulse, timeout_pulse;
  logic                  ie_bit;

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == ADDR_CTRL);

  final_project_req_ack_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .hw_ack        (hw_ack),
    .hw_req        (hw_req),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .timeout_pulse (timeout_pulse)
  );

  // Any attempt to change the command or restart while busy is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    err_set = 1'b0;
    start   = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          if (busy) err_set = 1'b1;
          else      data_d  = writedata[DATA_WIDTH-1:0];
        end
        ADDR_CTRL: begin
          if (writedata[CTRL_GO]) begin
            if (busy) err_set = 1'b1;
            else      start   = 1'b1;
          end
        end
        ADDR_OUTSET: begin
          if (busy) err_set = 1'b1;
          else      data_d  = data_q | writedata[DATA_WIDTH-1:0];
        end
        default: begin
          if (busy) err_set = 1'b1;
          else      data_d  = data_q & ~writedata[DATA_WIDTH-1:0];
        end
      endcase
    end
  end

  // Sticky flags: hardware set wins over a same-cycle W1C.
  assign done_d = (done_q & ~(ctrl_wr & writedata[CTRL_DONE])) | done_pulse;
  assign err_d  = (err_q  & ~(ctrl_wr & writedata[CTRL_ERR]))  | err_set;
  assign tmo_d  = (tmo_q  & ~(ctrl_wr & writedata[CTRL_TMO]))  | timeout_pulse;

`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
  logic ie_q, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) ie_q <= writedata[CTRL_IE];
      irq_q <= ie_q & (done_q | tmo_q);
    end
  end

  assign ie_bit = ie_q;
  assign irq    = irq_q;
`else
  assign ie_bit = 1'b0;
`endif

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d = 32'(data_q);
      ADDR_CTRL: begin
        rd_d[CTRL_BUSY] = busy;
        rd_d[CTRL_DONE] = done_q;
        rd_d[CTRL_ERR]  = err_q;
        rd_d[CTRL_TMO]  = tmo_q;
        rd_d[CTRL_IE]   = ie_bit;
      end
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      readdata <= '0;
    end else begin
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      readdata <= rd_d;
    end
  end

  assign out_port = data_q;

endmodule

// File: tb/tb_final_project_hardware_start_pio.sv
// Randomized bench for the start PIO against a register-level model of the programmer's view.
module tb_final_project_hardware_start_pio;

  localparam logic [7:0] Rv    = 8'h5A;
  localparam logic [1:0] AData = 2'd0;
  localparam logic [1:0] ACtrl = 2'd1;
  localparam logic [1:0] ASet  = 2'd2;
  localparam logic [1:0] AClr  = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        hw_req;
  logic        hw_ack = 1'b0;
`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  final_project_hardware_start_pio #(
    .DATA_WIDTH     (8),
    .RESET_VALUE    (Rv),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .hw_req     (hw_req),
    .hw_ack     (hw_ack)
`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  int total = 0;
  int bad = 0;

  // Programmer-visible model
  logic [7:0] m_data = Rv;
  bit m_done = 0, m_err = 0, m_tmo = 0, m_ie = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ctrl();
    return {27'd0, m_ie, m_tmo, m_err, m_done, 1'b0};
  endfunction

  function automatic logic [31:0] ie_word();
    return m_ie ? 32'h10 : 32'h0;
  endfunction

  task automatic m_write(input logic [1:0] a, input logic [31:0] d, input bit busy);
    case (a)
      AData: if (busy) m_err = 1; else m_data = d[7:0];
      ASet:  if (busy) m_err = 1; else m_data = m_data | d[7:0];
      AClr:  if (busy) m_err = 1; else m_data = m_data & ~d[7:0];
      default: begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
        if (d[3]) m_tmo = 0;
`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
        m_ie = d[4];
`endif
        if (d[0] && busy) m_err = 1;
      end
    endcase
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic model_wr(input logic [1:0] a, input logic [31:0] d, input bit busy);
    m_write(a, d, busy);
    wr(a, d);
  endtask

  // Successful handshake: ack rises d cycles after req, falls r cycles later.
  task automatic handshake(input int d, input int r, input logic [2:0] clr);
    model_wr(ACtrl, ie_word() | {28'd0, clr, 1'b1}, 0);
    check("req_up", hw_req, 1);
    repeat (d) @(negedge clk);
    check("req_held", hw_req, 1);
    hw_ack = 1;
    @(negedge clk);
    check("req_drop", hw_req, 0);
    repeat (r) @(negedge clk);
    hw_ack = 0;
    @(negedge clk);
    m_done = 1;
  endtask

  task automatic timeout_run();
    int n;
    model_wr(ACtrl, ie_word() | 32'h1, 0);
    n = 0;
    while (hw_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    m_tmo = 1;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    check({tag, "_out"}, 32'(out_port), 32'(m_data));
    rd(ACtrl, v);
    check({tag, "_ctrl"}, v, m_ctrl());
  endtask

  logic [31:0] v;
  int hi;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req", hw_req, 0);
    check("rst_out", 32'(out_port), 32'(Rv));
    check("rst_rd", readdata, 0);
    reset_n = 1;
    rd(AData, v); check("rd_data", v, 32'(Rv));
    rd(ACtrl, v); check("rd_ctrl", v, 0);
    rd(ASet, v);  check("rd_set", v, 0);
    rd(AClr, v);  check("rd_clr", v, 0);

    model_wr(AData, 32'hA5, 0);
    check("data_out", 32'(out_port), 32'(m_data));
    rd(AData, v); check("data_rd", v, 32'h0000_00A5);

    handshake(3, 0, 3'b000);
    check_state("hs1");
    model_wr(ACtrl, 32'h2, 0);
    check_state("w1c_done");

    // Writes while busy are rejected, one handshake only
    model_wr(ACtrl, 32'h1, 0);
    rd(ACtrl, v); check("busy_flag", 32'(v[0]), 1);
    model_wr(AData, 32'hFF, 1);
    check("busy_out", 32'(out_port), 32'(m_data));
    model_wr(ACtrl, 32'h1, 1);
    hw_ack = 1;
    @(negedge clk);
    hw_ack = 0;
    repeat (2) @(negedge clk);
    m_done = 1;
    check_state("busy");
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (hw_req) hi++;
    end
    check("no_second_hs", 32'(hi), 0);

    timeout_run();
    check_state("tmo");

    model_wr(AData, 32'h00, 0);
    model_wr(ASet, 32'h0F, 0);
    model_wr(AClr, 32'h03, 0);
    check("setclr", 32'(out_port), 32'h0C);

    // Set beats a same-cycle W1C of DONE
    handshake(1, 1, 3'b111);
    check_state("pre_race");
    model_wr(ACtrl, ie_word() | 32'h1, 0);
    @(negedge clk);
    hw_ack = 1;
    @(negedge clk);
    hw_ack = 0;
    chipselect = 1; write_n = 0; address = ACtrl; writedata = ie_word() | 32'h2;
    @(negedge clk);
    chipselect = 0; write_n = 1;
    m_done = 1;
    check_state("race");

`ifdef FINAL_PROJECT_START_PIO_IRQ_EN
    model_wr(ACtrl, 32'h1E, 0);
    @(negedge clk);
    check("irq_idle", irq, 0);
    handshake(2, 1, 3'b000);
    check("irq_lag", irq, 0);
    @(negedge clk);
    check("irq_set", irq, 1);
    model_wr(ACtrl, 32'h1E, 0);
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_clr", irq, 0);
    check_state("irq");
`endif

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 7))
        0: model_wr(AData, $urandom, 0);
        1: model_wr(ASet, $urandom, 0);
        2: model_wr(AClr, $urandom, 0);
        3, 6: handshake($urandom_range(0, 12), $urandom_range(0, 5), 3'($urandom));
        4: model_wr(ACtrl, ie_word() | {28'd0, 3'($urandom), 1'b0}, 0);
        5: timeout_run();
        default: model_wr(AData, $urandom, 0);
      endcase
      check_state("rand");
    end

    // Reset in the middle of REQ
    model_wr(AData, 32'h77, 0);
    wr(ACtrl, ie_word() | 32'h1);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("mid_rst_req", hw_req, 0);
    check("mid_rst_out", 32'(out_port), 32'(Rv));
    m_data = Rv; m_done = 0; m_err = 0; m_tmo = 0; m_ie = 0;
    @(negedge clk);
    reset_n = 1;
    check_state("after_rst");
    rd(AData, v); check("after_rst_data", v, 32'(Rv));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/final_project_hardware_start_pio.md
Name: final_project_hardware_start_pio

Overview:
- Avalon-MM write/read slave that sends a command from the Nios II side to custom hardware.
- This is the command path opposite the hardware-done input PIO: software loads an 8-bit command and writes GO; the block runs a four-phase req/ack handshake on the hardware side.
- Completion, error and timeout status are sticky and readable over the bus.
- Sits beside the input PIO on the same Avalon interconnect.

Parameters:
- DATA_WIDTH, 8: width of out_port and the DATA register.
- RESET_VALUE, 0: reset value of DATA/out_port.
- TIMEOUT_CYCLES, 1024: cycles allowed in each wait state before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  command value to hardware.
- hw_req  output  1  handshake request.
- hw_ack  input  1  handshake acknowledge; already synchronous to clk.
- irq  output  1  interrupt (present only with the optional feature).

Behaviour:
- Reset is asynchronous, active-low. All state, readdata, hw_req and irq are asynchronously reset to 0; out_port/DATA resets to RESET_VALUE.
- Register map:
  - 0 DATA: RW, DATA_WIDTH bits, zero-extended on read.
  - 1 CTRL: write bit0 GO, bit1 DONE W1C, bit2 ERR W1C, bit3 TMO W1C. Read bit0 BUSY, bit1 DONE, bit2 ERR, bit3 TMO.
  - 2 OUTSET: write sets DATA |= writedata[DATA_WIDTH-1:0]. Reads 0.
  - 3 OUTCLR: write sets DATA &= ~writedata[DATA_WIDTH-1:0]. Reads 0.
- readdata is updated every cycle from the address-selected mux, giving one-cycle read latency. It does not depend on chipselect.
- Handshake FSM states are IDLE, REQ and RELEASE. BUSY = (state != IDLE).
  - IDLE: a CTRL write with GO=1 goes to REQ and clears the timeout counter.
  - REQ: hw_req=1. hw_ack=1 goes to RELEASE and clears the counter.
  - RELEASE: hw_req=0. hw_ack=0 goes to IDLE and sets DONE.
- hw_req is a registered output: high exactly while state==REQ, asserting the cycle after the GO write.
- Timeout: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 in REQ or RELEASE, the FSM goes to IDLE, drops hw_req and sets TMO. DONE is not set.
- Writes while BUSY:
  - GO is ignored and sets ERR.
  - Writes to DATA, OUTSET or OUTCLR are ignored and set ERR, so out_port stays stable through the handshake.
  - W1C bits in the same CTRL write still take effect.
- Single CTRL write with GO=1 and W1C bits in IDLE: the bits are cleared first, then the start proceeds.
- Hardware set of DONE/TMO/ERR in the same cycle as a W1C clear of that bit: set wins.
- hw_ack=1 while in IDLE has no effect; a GO issued then enters REQ and completes on the next cycle (ack already high).

Optional Feature:
- Macro: FINAL_PROJECT_START_PIO_IRQ_EN.
- Defined:
  - CTRL bit4 is IE (RW).
  - irq is registered: irq = IE & (DONE | TMO), one cycle after the flag sets.
  - irq deasserts one cycle after W1C clears both flags.
- Undefined: the irq port and IE are absent, and CTRL bit4 reads 0.

Decomposition:
- Package final_project_pio_pkg holds:
  - address constants ADDR_DATA/CTRL/OUTSET/OUTCLR;
  - CTRL bit-position constants;
  - the handshake state enum (IDLE/REQ/RELEASE).
- Sub-module final_project_req_ack_fsm holds the FSM plus timeout counter. Inputs: start, hw_ack. Outputs: hw_req, busy, done_pulse, timeout_pulse.
- The top level holds the bus decode, registers and read mux.

Test Plan:
- Reset, then read each address → 0x0/RESET_VALUE. Write DATA=0xA5 → out_port=0xA5 and read-back of 0x000000A5 one cycle after address is set.
- Write CTRL=0x1 → hw_req=1 next cycle, BUSY=1. hw_ack=1 after 3 cycles → hw_req=0. hw_ack=0 → BUSY=0, DONE=1. Write CTRL=0x2 → DONE=0.
- While BUSY, write DATA=0xFF and CTRL=0x1 → out_port unchanged, ERR=1, exactly one handshake completes.
- With TIMEOUT_CYCLES=16 and hw_ack held 0 after GO → abort after 16 cycles in REQ: hw_req=0, TMO=1, DONE=0.
- OUTSET 0x0F then OUTCLR 0x03 from DATA=0x00 → out_port=0x0C. Reset asserted mid-REQ → hw_req=0 immediately, state IDLE, DATA=RESET_VALUE.
- With FINAL_PROJECT_START_PIO_IRQ_EN and IE=1, complete a handshake → irq=1 one cycle after DONE sets. W1C DONE in the same cycle a new DONE sets → DONE stays 1.
